// File: rtl/commit_monitor_pkg.sv
// Shared encodings and FSM states for the commit monitor.
package commit_monitor_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;
    localparam logic [31:0] NOP_INST    = 32'h00000013;
    localparam logic [4:0]  A0_IDX      = 5'd10;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

endpackage

// File: rtl/commit_watchdog.sv
// No-commit watchdog: counts idle cycles while enabled and flags expiry
// on the cycle the count reaches TIMEOUT-1 with no commit present.
module commit_watchdog #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_valid,
    output logic o_expire
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT - 1);

    logic [31:0] r_idle;

    // Idle counter: a commit restarts it, it holds while the monitor is not running.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle <= '0;
        end else if (i_en) begin
            r_idle <= i_valid ? 32'd0 : r_idle + 32'd1;
        end
    end

    // A commit in the same cycle always wins over expiry.
    assign o_expire = (TIMEOUT != 0) && i_en && !i_valid && (r_idle == LIMIT);

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: shadows a0, counts cycles/instret, and after an
// ebreak (plus a drain interval) or a watchdog expiry presents the halt
// instruction and halt code to the downstream halt/trace block.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 100000,
    parameter logic [63:0] TIMEOUT_CODE = 64'h0000_0000_DEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [63:0] wb_pc,
    input  logic [31:0] wb_inst,
    input  logic        wb_rf_wen,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_rf_wdata,
    output logic [31:0] sim_inst,
    output logic [63:0] sim_r10,
    output logic        halted,
    output logic        timeout,
    output logic [63:0] halt_pc,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES);

    state_e      r_state;
    logic [31:0] r_drain_cnt;
    logic [63:0] r_a0;
    logic [63:0] r_last_pc;
    logic [63:0] r_halt_pc;
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;
    logic        r_halted;
    logic        r_timeout;
    logic [31:0] r_sim_inst;
    logic [63:0] r_sim_r10;

    logic w_run;
    logic w_ebreak;
    logic w_expire;

    assign w_run    = (r_state == RUN);
    assign w_ebreak = wb_valid && (wb_inst == EBREAK_INST);

    commit_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .i_en     (w_run),
        .i_valid  (wb_valid),
        .o_expire (w_expire)
    );

    // Monitor FSM; halt outputs are loaded on the same edge that enters HALTED.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_drain_cnt   <= '0;
            r_a0          <= '0;
            r_last_pc     <= '0;
            r_halt_pc     <= '0;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_sim_inst    <= NOP_INST;
            r_sim_r10     <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 64'd1;
                    if (wb_valid) begin
                        r_instret_cnt <= r_instret_cnt + 64'd1;
                        r_last_pc     <= wb_pc;
                        if (wb_rf_wen && wb_rd == A0_IDX) r_a0 <= wb_rf_wdata;
                    end
                    if (w_ebreak) begin
                        r_halt_pc   <= wb_pc;
                        r_drain_cnt <= DRAIN_INIT;
                        r_state     <= DRAIN;
                    end else if (w_expire) begin
                        r_halt_pc  <= r_last_pc;
                        r_timeout  <= 1'b1;
                        r_halted   <= 1'b1;
                        r_sim_inst <= EBREAK_INST;
                        r_sim_r10  <= TIMEOUT_CODE;
                        r_state    <= HALTED;
                    end
                end
                DRAIN: begin
                    // At least one DRAIN cycle follows the ebreak, so r_a0
                    // already holds any a0 write made by the ebreak itself.
                    r_cycle_cnt <= r_cycle_cnt + 64'd1;
                    if (r_drain_cnt == 32'd0) begin
                        r_halted   <= 1'b1;
                        r_sim_inst <= EBREAK_INST;
                        r_sim_r10  <= r_a0;
                        r_state    <= HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 32'd1;
                    end
                end
                HALTED: begin
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign sim_inst    = r_sim_inst;
    assign sim_r10     = r_sim_r10;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign halt_pc     = r_halt_pc;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: two instances (DRAIN=4/TIMEOUT=16 and
// DRAIN=0/no watchdog) share one stimulus stream; a timeline model
// predicts every output each cycle, and directed scenarios pin literals.
module tb_commit_monitor;
    import commit_monitor_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [63:0] wb_pc = '0;
    logic [31:0] wb_inst = NOP_INST;
    logic        wb_rf_wen = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_rf_wdata = '0;

    logic [31:0] o_inst [2];
    logic [63:0] o_r10  [2];
    logic [63:0] o_hpc  [2];
    logic [63:0] o_cyc  [2];
    logic [63:0] o_ret  [2];
    logic        o_halt [2];
    logic        o_to   [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    commit_monitor #(.DRAIN_CYCLES(4), .TIMEOUT(16), .TIMEOUT_CODE(64'hDEAD_BEEF)) u_dut0 (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_inst(wb_inst), .wb_rf_wen(wb_rf_wen), .wb_rd(wb_rd), .wb_rf_wdata(wb_rf_wdata),
        .sim_inst(o_inst[0]), .sim_r10(o_r10[0]), .halted(o_halt[0]), .timeout(o_to[0]),
        .halt_pc(o_hpc[0]), .cycle_cnt(o_cyc[0]), .instret_cnt(o_ret[0]));

    commit_monitor #(.DRAIN_CYCLES(0), .TIMEOUT(0), .TIMEOUT_CODE(64'hDEAD_BEEF)) u_dut1 (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_inst(wb_inst), .wb_rf_wen(wb_rf_wen), .wb_rd(wb_rd), .wb_rf_wdata(wb_rf_wdata),
        .sim_inst(o_inst[1]), .sim_r10(o_r10[1]), .halted(o_halt[1]), .timeout(o_to[1]),
        .halt_pc(o_hpc[1]), .cycle_cnt(o_cyc[1]), .instret_cnt(o_ret[1]));

    function automatic int drn(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic int tmo(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d got %h want %h @%0t", nm, i, act, exp, $time);
        end
    endtask

    // Timeline model: each instance either runs, or has a known cycle index
    // (m_halt_at) from which it is halted; counters follow the rules directly.
    bit          m_init = 1'b0;
    longint      m_now;
    bit          m_run     [2];
    bit          m_to      [2];
    longint      m_halt_at [2];
    int          m_idle    [2];
    logic [63:0] m_a0 [2], m_lpc [2], m_hpc [2], m_cyc [2], m_ret [2];

    function automatic bit m_halted(input int i);
        return !m_run[i] && (m_now >= m_halt_at[i]);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_init = 1'b1;
            m_now  = 0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 1'b1; m_to[i] = 1'b0; m_halt_at[i] = 64'sh7fff_ffff_ffff_ffff;
                m_idle[i] = 0; m_a0[i] = '0; m_lpc[i] = '0; m_hpc[i] = '0;
                m_cyc[i] = '0; m_ret[i] = '0;
            end
        end else if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                if (m_halted(i)) begin
                    // frozen
                end else if (!m_run[i]) begin
                    m_cyc[i] += 1;
                end else begin
                    m_cyc[i] += 1;
                    if (wb_valid) begin
                        m_ret[i] += 1;
                        m_lpc[i] = wb_pc;
                        if (wb_rf_wen && wb_rd == 5'd10) m_a0[i] = wb_rf_wdata;
                        m_idle[i] = 0;
                        if (wb_inst == 32'h00100073) begin
                            m_run[i] = 1'b0;
                            m_hpc[i] = wb_pc;
                            m_halt_at[i] = m_now + drn(i) + 2;
                        end
                    end else if (tmo(i) != 0 && m_idle[i] == tmo(i) - 1) begin
                        m_run[i] = 1'b0;
                        m_to[i] = 1'b1;
                        m_hpc[i] = m_lpc[i];
                        m_halt_at[i] = m_now + 1;
                    end else begin
                        m_idle[i]++;
                    end
                end
            end
            m_now++;
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clock) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                bit h;
                h = m_halted(i);
                chk("halted",   i, 64'(o_halt[i]), 64'(h));
                chk("timeout",  i, 64'(o_to[i]), 64'(h && m_to[i]));
                chk("sim_inst", i, 64'(o_inst[i]), h ? 64'h00100073 : 64'h00000013);
                chk("sim_r10",  i, o_r10[i], !h ? 64'd0 : (m_to[i] ? 64'hDEAD_BEEF : m_a0[i]));
                chk("halt_pc",  i, o_hpc[i], m_hpc[i]);
                chk("cycle",    i, o_cyc[i], m_cyc[i]);
                chk("instret",  i, o_ret[i], m_ret[i]);
            end
        end
    end

    task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                        input logic wen, input logic [4:0] rd, input logic [63:0] wd);
        wb_valid = v; wb_pc = pc; wb_inst = inst; wb_rf_wen = wen; wb_rd = rd; wb_rf_wdata = wd;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 64'd0, NOP_INST, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // Called just after the ebreak step; reports the cycle offset of halted=1.
    task automatic halt_lat(output int k0, output int k1);
        k0 = -1; k1 = -1;
        for (int k = 1; k <= 12; k++) begin
            if (o_halt[0] && k0 < 0) k0 = k;
            if (o_halt[1] && k1 < 0) k1 = k;
            if (k0 > 0 && k1 > 0) break;
            idle(1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int k0, k1, n;
        @(negedge clock);

        // Basic ebreak halt with a0 written three times.
        do_reset();
        step(1, 64'h8000_0000, 32'h00000513, 1, 5'd10, 64'd0);
        step(1, 64'h8000_0004, 32'h00500513, 1, 5'd10, 64'd5);
        step(1, 64'h8000_0008, 32'h00700513, 1, 5'd10, 64'd7);
        idle(1);
        step(1, 64'h8000_0010, EBREAK_INST, 0, 5'd0, 64'd0);
        halt_lat(k0, k1);
        chk("lat_drain4", 0, 64'(k0), 64'd6);
        chk("lat_drain0", 1, 64'(k1), 64'd2);
        idle(1);
        chk("t1_inst", 0, 64'(o_inst[0]), 64'h00100073);
        chk("t1_r10",  0, o_r10[0], 64'd7);
        chk("t1_hpc",  0, o_hpc[0], 64'h8000_0010);
        chk("t1_ret",  0, o_ret[0], 64'd4);
        chk("t1_to",   0, 64'(o_to[0]), 64'd0);

        // Writes to other registers must not touch the a0 shadow.
        do_reset();
        step(1, 64'h8000_0000, 32'h00000513, 1, 5'd10, 64'd0);
        step(1, 64'h8000_0004, 32'h00000593, 1, 5'd11, 64'h1234);
        step(1, 64'h8000_0008, 32'h00000013, 1, 5'd0,  64'h1234);
        step(1, 64'h8000_000c, EBREAK_INST, 0, 5'd0, 64'd0);
        idle(8);
        chk("t2_r10", 0, o_r10[0], 64'd0);
        chk("t2_r10", 1, o_r10[1], 64'd0);

        // Watchdog halt after one commit.
        do_reset();
        idle(1);
        step(1, 64'h8000_0000, 32'h00000013, 0, 5'd0, 64'd0);
        n = 0;
        while (!o_halt[0] && n < 40) begin idle(1); n++; end
        chk("t3_halt", 0, 64'(o_halt[0]), 64'd1);
        chk("t3_to",   0, 64'(o_to[0]), 64'd1);
        chk("t3_r10",  0, o_r10[0], 64'hDEAD_BEEF);
        chk("t3_hpc",  0, o_hpc[0], 64'h8000_0000);
        chk("t3_cyc",  0, o_cyc[0], 64'd18);
        chk("t3_nohalt", 1, 64'(o_halt[1]), 64'd0);

        // A commit on the last idle cycle keeps the watchdog quiet.
        do_reset();
        step(1, 64'h8000_0000, 32'h00000013, 0, 5'd0, 64'd0);
        idle(15);
        step(1, 64'h8000_0004, 32'h00000013, 0, 5'd0, 64'd0);
        chk("t4_halt_a", 0, 64'(o_halt[0]), 64'd0);
        idle(10);
        chk("t4_halt_b", 0, 64'(o_halt[0]), 64'd0);
        idle(10);

        // Reset during DRAIN clears everything; a later ebreak halts normally.
        do_reset();
        step(1, 64'h8000_0000, 32'h00900513, 1, 5'd10, 64'd9);
        step(1, 64'h8000_0004, EBREAK_INST, 0, 5'd0, 64'd0);
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 2; i++) begin
            chk("t5_halt", i, 64'(o_halt[i]), 64'd0);
            chk("t5_inst", i, 64'(o_inst[i]), 64'h00000013);
            chk("t5_r10",  i, o_r10[i], 64'd0);
            chk("t5_cyc",  i, o_cyc[i], 64'd0);
            chk("t5_ret",  i, o_ret[i], 64'd0);
        end
        reset = 1'b0;
        step(1, 64'h8000_0100, EBREAK_INST, 0, 5'd0, 64'd0);
        halt_lat(k0, k1);
        chk("t5_lat", 0, 64'(k0), 64'd6);
        chk("t5_lat", 1, 64'(k1), 64'd2);
        chk("t5_hpc", 0, o_hpc[0], 64'h8000_0100);
        chk("t5_r10", 0, o_r10[0], 64'd0);

        // Second ebreak right behind the first is ignored.
        do_reset();
        step(1, 64'h8000_0020, EBREAK_INST, 0, 5'd0, 64'd0);
        step(1, 64'h8000_0024, EBREAK_INST, 0, 5'd0, 64'd0);
        chk("t6_halt", 1, 64'(o_halt[1]), 64'd1);
        chk("t6_ret",  1, o_ret[1], 64'd1);
        chk("t6_hpc",  1, o_hpc[1], 64'h8000_0020);
        idle(6);
        chk("t6_ret",  0, o_ret[0], 64'd1);

        // Randomized traffic with varying commit density.
        for (int r = 0; r < 8; r++) begin
            int pv;
            logic [63:0] pc;
            do_reset();
            pv = $urandom_range(1, 10);
            pc = 64'h8000_0000;
            for (int c = 0; c < 90; c++) begin
                logic v;
                logic [31:0] inst;
                logic [4:0] rd;
                if ($urandom_range(0, 149) == 0) reset = 1'b1; else reset = 1'b0;
                v = ($urandom_range(0, 9) < pv);
                inst = ($urandom_range(0, 29) == 0) ? EBREAK_INST : $urandom;
                rd = ($urandom_range(0, 1) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
                step(v, pc, inst, 1'($urandom_range(0, 1)), rd, {$urandom, $urandom});
                if (v) pc += 64'd4;
            end
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Sits between the core's writeback stage and the simulation halt/trace block.
- Watches retiring instructions and keeps a shadow copy of a0 (x10).
- Detects ebreak retirement and waits a fixed drain interval before presenting ebreak plus the halt code to the downstream block.
- Also provides cycle/instret counters and a no-commit watchdog that forces a failing halt on hang.

Parameters:
- DRAIN_CYCLES, 4: cycles to wait after ebreak retires before raising the halt (0 allowed).
- TIMEOUT, 100000: consecutive no-commit cycles before a watchdog halt; 0 disables the watchdog.
- TIMEOUT_CODE, 64'h0000_0000_DEAD_BEEF: value driven on sim_r10 on a watchdog halt.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  one instruction retires this cycle.
- wb_pc  in  64  pc of the retiring instruction.
- wb_inst  in  32  encoding of the retiring instruction.
- wb_rf_wen  in  1  retiring instruction writes the register file.
- wb_rd  in  5  destination register index.
- wb_rf_wdata  in  64  register write data.
- sim_inst  out  32  instruction handed to the halt block.
- sim_r10  out  64  halt code handed to the halt block.
- halted  out  1  monitor is in HALTED.
- timeout  out  1  the halt was caused by the watchdog.
- halt_pc  out  64  pc of the ebreak, or of the last commit on timeout.
- cycle_cnt  out  64  cycles spent in RUN+DRAIN.
- instret_cnt  out  64  instructions retired in RUN.

Behaviour:
- Reset values (reset is synchronous):
  - state=RUN; all counters, a0 shadow, halt_pc and last_pc = 0.
  - halted=0, timeout=0.
  - sim_inst=32'h00000013 (nop), sim_r10=0.
- Shadow a0:
  - In RUN, on wb_valid && wb_rf_wen && wb_rd==10, a0 <= wb_rf_wdata.
  - Frozen in DRAIN and HALTED.
- last_pc <= wb_pc on every wb_valid in RUN.
- State RUN:
  - cycle_cnt += 1 every cycle; instret_cnt += 1 on wb_valid (the ebreak itself is counted).
  - ebreak is wb_valid && wb_inst==32'h00100073. On ebreak: halt_pc <= wb_pc, drain_cnt <= DRAIN_CYCLES, next state DRAIN.
  - Idle counter: cleared on wb_valid, otherwise incremented.
  - If TIMEOUT!=0, wb_valid=0 and idle==TIMEOUT-1: halt_pc <= last_pc, timeout <= 1, next state HALTED.
  - Priority: a commit in the same cycle clears idle, so a commit always beats the watchdog.
- State DRAIN:
  - cycle_cnt += 1.
  - If drain_cnt==0, go to HALTED; otherwise drain_cnt -= 1.
  - wb_valid is ignored; no counting, no shadow update.
- State HALTED (terminal until reset):
  - sim_inst=32'h00100073.
  - sim_r10 = a0 shadow, or TIMEOUT_CODE if timeout=1.
  - halted=1; all counters frozen.
- Outputs are registered:
  - sim_inst stays nop in every state except HALTED.
  - Ebreak retiring at the edge ending cycle t gives halted=1 in cycle t+2+DRAIN_CYCLES. With DRAIN_CYCLES=0 that is the second cycle after retirement.
- Boundaries:
  - Back-to-back commits are fine.
  - Ebreak with wb_rf_wen=1 and wb_rd=10 is treated as a normal commit first: the shadow takes the new value, then DRAIN.
  - A second ebreak during DRAIN is ignored.
  - Counters wrap modulo 2^64.
  - Reset asserted in any state returns everything to reset values on the next edge, with no residual halt.

Decomposition:
- Shared package holds:
  - EBREAK_INST = 32'h00100073 and NOP_INST = 32'h00000013.
  - A0_IDX = 5'd10.
  - The state enum {RUN, DRAIN, HALTED}.
- One natural sub-module, commit_watchdog: the idle counter plus compare. It outputs expire given wb_valid, an enable (state==RUN) and TIMEOUT.

Test Plan:
- Reset then 3 commits of addi a0 (rd=10, wdata=0, then 5, then 7), then ebreak at pc 0x80000010, DRAIN_CYCLES=4 -> halted=1 exactly 6 cycles after the ebreak cycle, with:
  - sim_inst=0x00100073, sim_r10=7, halt_pc=0x80000010.
  - instret_cnt=4, timeout=0.
- Writes to rd=11 and rd=0 with wdata=0x1234 before ebreak -> sim_r10 keeps the prior a0 value (0).
- TIMEOUT=16, one commit at pc 0x80000000, then wb_valid held 0 -> halted=1 with timeout=1, sim_r10=0xDEADBEEF, halt_pc=0x80000000. Frozen cycle_cnt is 1+16+1, exact value checked by the bench.
- Commit arriving on the cycle idle==TIMEOUT-1 -> no timeout; idle restarts; halted stays 0.
- Reset pulsed during DRAIN (2 cycles after ebreak) -> all outputs return to reset values, sim_inst=0x00000013; a later ebreak halts normally.
- DRAIN_CYCLES=0 with ebreak and a second ebreak the next cycle -> halted two cycles after the first ebreak, instret_cnt counts only the first ebreak, halt_pc is the first ebreak's pc.
